// File: rtl/meet_counter_ctrl.sv
// Purpose : up/down counter pair that starts at 0 / load_val_i and steps toward each
//           other until the two counters meet (even load) or cross (odd load).
// Latency : with every cycle stepping, done_o rises ceil(L/2)+2 cycles after the start edge.
// Backpressure: step_en_i stalls stepping in RUN; start_i is ignored unless idle;
//           abort_i cancels a run.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start_i, load_val_i run request and initial down-count (sampled in IDLE)
//   step_en_i, abort_i  step qualifier and run cancel
//   div_val_i           step prescale, present only when STEP_DIV_EN is defined
//   count_up_o, count_down_o, step_cnt_o  counter state
//   busy_o, done_o, meet_o, crossed_o     status (meet/crossed sticky until next start)
// Configuration macro: STEP_DIV_EN adds the div_val_i port and the step prescaler.
module meet_counter_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_en_i,
    input  logic             abort_i,
`ifdef STEP_DIV_EN
    input  logic [DIV_W-1:0] div_val_i,
`endif
    output logic [WIDTH-1:0] count_up_o,
    output logic [WIDTH-1:0] count_down_o,
    output logic [WIDTH-1:0] step_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             meet_o,
    output logic             crossed_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A prescaler narrower than one bit cannot hold a divide value.
    if (DIV_W < 1) begin : g_div_w_too_small
    end

    state_e           state_q;
    logic [WIDTH-1:0] count_up_q;
    logic [WIDTH-1:0] count_down_q;
    logic [WIDTH-1:0] step_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             meet_q;
    logic             crossed_q;
    logic             converged;

    // Unsigned compare on the registered counters; once true no further step is taken,
    // so neither counter can wrap.
    assign converged = (count_up_q >= count_down_q);

`ifdef STEP_DIV_EN
    logic [DIV_W-1:0] presc_q;
    logic             step_ok;

    // A step qualifies on the step_en cycle where the prescaler has reached div_val_i.
    assign step_ok = (presc_q == div_val_i);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_up_q   <= '0;
            count_down_q <= '0;
            step_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            meet_q       <= 1'b0;
            crossed_q    <= 1'b0;
`ifdef STEP_DIV_EN
            presc_q      <= '0;
`endif
        end else begin
            // done is the registered image of the DONE state: one cycle, after DONE.
            done_q <= (state_q == ST_DONE);

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        count_up_q   <= '0;
                        count_down_q <= load_val_i;
                        step_cnt_q   <= '0;
                        meet_q       <= 1'b0;
                        crossed_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_RUN;
`ifdef STEP_DIV_EN
                        presc_q      <= '0;
`endif
                    end
                end

                ST_RUN: begin
                    if (abort_i) begin
                        // Counters hold their partial values; meet/crossed stay cleared.
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`ifdef STEP_DIV_EN
                        presc_q <= '0;
`endif
                    end else if (converged) begin
                        meet_q    <= (count_up_q == count_down_q);
                        crossed_q <= (count_up_q > count_down_q);
                        busy_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (step_en_i) begin
`ifdef STEP_DIV_EN
                        if (step_ok) begin
                            count_up_q   <= count_up_q + 1'b1;
                            count_down_q <= count_down_q - 1'b1;
                            step_cnt_q   <= step_cnt_q + 1'b1;
                            presc_q      <= '0;
                        end else begin
                            presc_q      <= presc_q + 1'b1;
                        end
`else
                        count_up_q   <= count_up_q + 1'b1;
                        count_down_q <= count_down_q - 1'b1;
                        step_cnt_q   <= step_cnt_q + 1'b1;
`endif
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign count_up_o   = count_up_q;
    assign count_down_o = count_down_q;
    assign step_cnt_o   = step_cnt_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign meet_o       = meet_q;
    assign crossed_o    = crossed_q;

endmodule

// File: tb/tb_meet_counter_ctrl.sv
module tb_meet_counter_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV_W = 4;
    localparam int MAXC  = 1023;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             step_en  = 1'b0;
    logic             abort    = 1'b0;
`ifdef STEP_DIV_EN
    logic [DIV_W-1:0] div_val  = '0;
`endif
    logic [WIDTH-1:0] count_up;
    logic [WIDTH-1:0] count_down;
    logic [WIDTH-1:0] step_cnt;
    logic             busy;
    logic             done;
    logic             meet;
    logic             crossed;

    int n_checks = 0;
    int n_pass   = 0;
    logic en_pat [1:MAXC];

    always #5 clk = ~clk;

    meet_counter_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .load_val_i   (load_val),
        .step_en_i    (step_en),
        .abort_i      (abort),
`ifdef STEP_DIV_EN
        .div_val_i    (div_val),
`endif
        .count_up_o   (count_up),
        .count_down_o (count_down),
        .step_cnt_o   (step_cnt),
        .busy_o       (busy),
        .done_o       (done),
        .meet_o       (meet),
        .crossed_o    (crossed)
    );

    // mode 0: step_en always high, 1: high on odd cycles, 2: random (~75% high)
    task automatic fill_pat(input int mode);
        for (int i = 1; i <= MAXC; i++) begin
            case (mode)
                0:       en_pat[i] = 1'b1;
                1:       en_pat[i] = (i % 2 == 1);
                default: en_pat[i] = ($urandom_range(3, 0) != 0);
            endcase
        end
    endtask

    // One full run checked against the arithmetic model: the run takes ceil(L/2) steps,
    // each step consumes dv+1 step_en-high cycles, and done follows 2 cycles after the
    // last step (detect cycle + DONE). A second start at restart_at must be ignored.
    task automatic run_and_check(input string name, input int L, input int dv,
                                 input int restart_at);
        int s, need, cnt, exp_c, got_c;
        s     = (L + 1) / 2;
        need  = s * (dv + 1);
        exp_c = 2;
        cnt   = 0;
        if (need > 0) begin
            for (int i = 1; i <= MAXC; i++) begin
                if (en_pat[i]) cnt++;
                if (cnt == need) begin
                    exp_c = i + 2;
                    break;
                end
            end
        end

        @(posedge clk); #1;
        start    = 1'b1;
        load_val = WIDTH'(L);
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %0b expected 1", name, busy);
        else n_pass++;

        got_c = 0;
        for (int c = 1; c <= MAXC; c++) begin
            step_en = en_pat[c];
            start   = (c == restart_at);
            if (c == restart_at) load_val = 8'd3;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got_c = c;
                break;
            end
        end
        start   = 1'b0;
        step_en = 1'b0;

        n_checks++;
        if (got_c !== exp_c) $display("FAIL %s done_cycle: got %0d expected %0d", name, got_c, exp_c);
        else n_pass++;
        n_checks++;
        if (count_up !== WIDTH'(s)) $display("FAIL %s count_up: got %0d expected %0d", name, count_up, s);
        else n_pass++;
        n_checks++;
        if (count_down !== WIDTH'(L - s)) $display("FAIL %s count_down: got %0d expected %0d", name, count_down, L - s);
        else n_pass++;
        n_checks++;
        if (step_cnt !== WIDTH'(s)) $display("FAIL %s step_cnt: got %0d expected %0d", name, step_cnt, s);
        else n_pass++;
        n_checks++;
        if (meet !== (L % 2 == 0)) $display("FAIL %s meet: got %0b expected %0b", name, meet, (L % 2 == 0));
        else n_pass++;
        n_checks++;
        if (crossed !== (L % 2 == 1)) $display("FAIL %s crossed: got %0b expected %0b", name, crossed, (L % 2 == 1));
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %0b expected 0", name, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL %s done_width: got %0b expected 0", name, done);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({count_up, count_down, step_cnt, busy, done, meet, crossed} !== '0)
            $display("FAIL reset_outputs: got up=%0d down=%0d steps=%0d busy=%0b done=%0b meet=%0b crossed=%0b expected all 0",
                     count_up, count_down, step_cnt, busy, done, meet, crossed);
        else n_pass++;
    endtask

    task automatic test_meet_even();
        fill_pat(0);
        run_and_check("even10", 10, 0, 0);
    endtask

    task automatic test_crossed_odd();
        fill_pat(0);
        run_and_check("odd9", 9, 0, 0);
        run_and_check("zero", 0, 0, 0);
        run_and_check("one", 1, 0, 0);
        run_and_check("max255", 255, 0, 0);
    endtask

    task automatic test_toggle_restart();
        fill_pat(1);
        run_and_check("toggle10", 10, 0, 3);
    endtask

    task automatic test_abort();
        int done_seen;
        fill_pat(0);
        @(posedge clk); #1;
        start    = 1'b1;
        load_val = 8'd10;
        @(posedge clk); #1;
        start   = 1'b0;
        step_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", busy);
        else n_pass++;
        done_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        step_en = 1'b0;
        n_checks++;
        if (count_up !== 8'd3 || count_down !== 8'd7 || step_cnt !== 8'd3)
            $display("FAIL abort_hold: got up=%0d down=%0d steps=%0d expected 3/7/3", count_up, count_down, step_cnt);
        else n_pass++;
        n_checks++;
        if (meet !== 1'b0 || crossed !== 1'b0)
            $display("FAIL abort_flags: got meet=%0b crossed=%0b expected 0/0", meet, crossed);
        else n_pass++;
        n_checks++;
        if (done_seen != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", done_seen);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            fill_pat(2);
            run_and_check("random", int'($urandom_range(255, 0)), 0, 0);
        end
    endtask

`ifdef STEP_DIV_EN
    task automatic test_prescale();
        fill_pat(0);
        div_val = 4'd3;
        run_and_check("div3_l4", 4, 3, 0);
        fill_pat(2);
        div_val = 4'd1;
        run_and_check("div1_rand", 23, 1, 0);
        div_val = 4'd0;
    endtask
`endif

    task automatic test_reset_midrun();
        fill_pat(0);
        @(posedge clk); #1;
        start    = 1'b1;
        load_val = 8'd40;
        @(posedge clk); #1;
        start   = 1'b0;
        step_en = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({count_up, count_down, step_cnt, busy, done, meet, crossed} !== '0)
            $display("FAIL reset_midrun: got up=%0d down=%0d steps=%0d busy=%0b expected all 0",
                     count_up, count_down, step_cnt, busy);
        else n_pass++;
        step_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || count_up !== 8'd0) $display("FAIL reset_idle_after: got busy=%0b up=%0d expected 0/0", busy, count_up);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_meet_even();
        test_crossed_odd();
        test_toggle_restart();
        test_abort();
        test_random();
`ifdef STEP_DIV_EN
        test_prescale();
`endif
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
